t_ff_mod_counter: RTL and testbench

- Parametrised successor to the single-bit T flip-flop: a WIDTH-bit register built from toggle cells.
- Two modes:
  - Bank mode: each bit toggles on its own t input.
  - Counter mode: modulo-(MAX+1) up/down counter with synchronous load, terminal-count flag and wrap pulse.
- Used as a general toggle register or a small event/period counter in the FlipFlops/counter family.

---
 rtl/t_ff_mod_counter.sv | 93 +++++++++
 tb/tb_t_ff_mod_counter.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/t_ff_mod_counter.sv
// ============================================================================
// Module   : t_ff_mod_counter
// Purpose  : WIDTH-bit toggle-cell register; independent T bank or
//            modulo-(MAX+1) up/down counter with load, tc and wrap pulse.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module t_ff_mod_counter #(
  parameter int WIDTH = 4,
  parameter int MAX   = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             mode,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  input  logic [WIDTH-1:0] t,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qn,
  output logic             tc,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] C_MAX = WIDTH'(MAX);

  logic [WIDTH-1:0] r_q;
  logic             r_wrap;

  logic             w_at_max;
  logic             w_at_zero;
  logic             w_above_max;
  logic [WIDTH-1:0] w_cnt_next;
  logic             w_cnt_wrap;
  logic [WIDTH-1:0] w_tv;
  logic [WIDTH-1:0] w_load_val;

  assign w_at_max    = (r_q == C_MAX);
  assign w_at_zero   = (r_q == '0);
  assign w_above_max = (r_q > C_MAX);

  // Out-of-range states recover toward the legal range in the count direction.
  always_comb begin
    w_cnt_next = r_q;
    w_cnt_wrap = 1'b0;
    if (up_dn) begin
      if (w_at_max || w_above_max) begin
        w_cnt_next = '0;
        w_cnt_wrap = 1'b1;
      end else begin
        w_cnt_next = r_q + WIDTH'(1);
      end
    end else begin
      if (w_above_max) begin
        w_cnt_next = C_MAX;
      end else if (w_at_zero) begin
        w_cnt_next = C_MAX;
        w_cnt_wrap = 1'b1;
      end else begin
        w_cnt_next = r_q - WIDTH'(1);
      end
    end
  end

  // Counting is folded into a toggle vector so both modes share one T path.
  assign w_tv       = mode ? t : (r_q ^ w_cnt_next);
  assign w_load_val = (mode || (d <= C_MAX)) ? d : C_MAX;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q    <= '0;
      r_wrap <= 1'b0;
    end else if (load) begin
      r_q    <= w_load_val;
      r_wrap <= 1'b0;
    end else if (en) begin
      r_q    <= r_q ^ w_tv;
      r_wrap <= ~mode & w_cnt_wrap;
    end else begin
      r_wrap <= 1'b0;
    end
  end

  assign q    = r_q;
  assign qn   = ~r_q;
  assign tc   = ~mode & (up_dn ? w_at_max : w_at_zero);
  assign wrap = r_wrap;

endmodule

`default_nettype wire

// File: tb/tb_t_ff_mod_counter.sv
// Self-checking bench for t_ff_mod_counter (WIDTH=4, MAX=9): arithmetic
// reference model compared every cycle plus literal directed expectations.
`default_nettype none

module tb_t_ff_mod_counter;

  localparam int WIDTH = 4;
  localparam int MAX   = 9;

  logic             clk = 1'b0;
  logic             rst;
  logic             en;
  logic             mode;
  logic             up_dn;
  logic             load;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] t;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] qn;
  logic             tc;
  logic             wrap;

  int n_cmp = 0;
  int n_bad = 0;

  int m_q    = 0;
  int m_wrap = 0;

  t_ff_mod_counter #(.WIDTH(WIDTH), .MAX(MAX)) dut (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .mode (mode),
    .up_dn(up_dn),
    .load (load),
    .d    (d),
    .t    (t),
    .q    (q),
    .qn   (qn),
    .tc   (tc),
    .wrap (wrap)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: plain modular arithmetic on integers.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_q    <= 0;
      m_wrap <= 0;
    end else if (load) begin
      m_q    <= mode ? int'(d) : ((int'(d) > MAX) ? MAX : int'(d));
      m_wrap <= 0;
    end else if (!en) begin
      m_wrap <= 0;
    end else if (mode) begin
      m_q    <= m_q ^ int'(t);
      m_wrap <= 0;
    end else if (up_dn) begin
      m_q    <= (m_q >= MAX) ? 0 : (m_q + 1) % (MAX + 1);
      m_wrap <= (m_q >= MAX) ? 1 : 0;
    end else begin
      m_q    <= (m_q == 0 || m_q > MAX) ? MAX : m_q - 1;
      m_wrap <= (m_q == 0) ? 1 : 0;
    end
  end

  always @(negedge clk) begin
    chk("model_q",    32'(q),    32'(m_q));
    chk("model_qn",   32'(qn),   32'((~m_q) & ((1 << WIDTH) - 1)));
    chk("model_wrap", 32'(wrap), 32'(m_wrap));
    chk("model_tc",   32'(tc),   32'((!mode && (up_dn ? (m_q == MAX) : (m_q == 0))) ? 1 : 0));
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  int exp_up[12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
  int exp_dn[4]  = '{1, 0, 9, 8};

  initial begin
    rst = 1'b1; d = 4'hA; load = 1'b1; en = 1'b1;
    mode = 1'b0; up_dn = 1'b1; t = 4'h0;
    tick(); tick();
    chk("reset_q", 32'(q), 32'h0);
    chk("reset_qn", 32'(qn), 32'hF);
    chk("reset_wrap", 32'(wrap), 32'h0);

    rst = 1'b0; load = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      chk("up_q", 32'(q), 32'(exp_up[i]));
      chk("up_tc", 32'(tc), (exp_up[i] == 9) ? 32'h1 : 32'h0);
      chk("up_wrap", 32'(wrap), (i == 9) ? 32'h1 : 32'h0);
    end

    load = 1'b1; d = 4'h2;
    tick();
    chk("dn_load", 32'(q), 32'h2);
    load = 1'b0; up_dn = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("dn_q", 32'(q), 32'(exp_dn[i]));
      chk("dn_tc", 32'(tc), (exp_dn[i] == 0) ? 32'h1 : 32'h0);
      chk("dn_wrap", 32'(wrap), (exp_dn[i] == 9) ? 32'h1 : 32'h0);
    end

    load = 1'b1; en = 1'b1; d = 4'hE; up_dn = 1'b1;
    tick();
    chk("clamp_q", 32'(q), 32'h9);
    chk("clamp_wrap", 32'(wrap), 32'h0);
    load = 1'b0;
    tick();
    chk("clamp_next_q", 32'(q), 32'h0);
    chk("clamp_next_wrap", 32'(wrap), 32'h1);
    en = 1'b0;
    tick(); tick();
    chk("hold_q", 32'(q), 32'h0);
    chk("hold_wrap", 32'(wrap), 32'h0);

    mode = 1'b1; load = 1'b1; d = 4'h0;
    tick();
    load = 1'b0; en = 1'b1; t = 4'b0101;
    tick();
    chk("bank_q1", 32'(q), 32'h5);
    chk("bank_qn1", 32'(qn), 32'hA);
    chk("bank_tc1", 32'(tc), 32'h0);
    tick();
    chk("bank_q2", 32'(q), 32'h0);
    chk("bank_qn2", 32'(qn), 32'hF);
    t = 4'b0000;
    tick();
    chk("bank_hold", 32'(q), 32'h0);
    chk("bank_wrap", 32'(wrap), 32'h0);

    load = 1'b1; d = 4'hF;
    tick();
    chk("bank_load_unclamped", 32'(q), 32'hF);
    load = 1'b0; mode = 1'b0; up_dn = 1'b1;
    chk("switch_keeps_q", 32'(q), 32'hF);
    tick();
    chk("oor_up_q", 32'(q), 32'h0);
    chk("oor_up_wrap", 32'(wrap), 32'h1);

    mode = 1'b1; load = 1'b1; d = 4'hC;
    tick();
    load = 1'b0; mode = 1'b0; up_dn = 1'b0;
    tick();
    chk("oor_dn_q", 32'(q), 32'h9);
    chk("oor_dn_wrap", 32'(wrap), 32'h0);

    up_dn = 1'b1; load = 1'b1; d = 4'h7;
    tick();
    chk("pre_rst_q", 32'(q), 32'h7);
    load = 1'b0; en = 1'b1;
    rst = 1'b1;
    #1;
    chk("async_rst_q", 32'(q), 32'h0);
    chk("async_rst_qn", 32'(qn), 32'hF);
    tick();
    rst = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk("resume_q", 32'(q), 32'(i));
    end

    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
